// File: rtl/multi_clk_divider.sv
// ----------------------------------------------------------------------------
// multi_clk_divider
//
// Multi-channel programmable clock divider / tick generator. Each channel
// owns a BW-bit down-counter that reloads from its active divisor at terminal
// count. New divisors are written through a valid/ready port into a per-channel
// shadow register and only become active at the next terminal count (or at
// once while the channel is disabled), so a running output never glitches.
//
// Optional feature: define MCD_PRESCALE_EN to insert a shared prescaler that
// issues one count tick every PRESCALE clocks. Without it every clock is a tick
// and no prescaler logic exists.
//
// Ports:
//   CLK          clock
//   RST          synchronous active-high reset
//   EN_i         per-channel count enable
//   MODE_i       per-channel mode: 0 = toggle, 1 = pulse
//   CFG_VALID_i  configuration write request
//   CFG_CH_i     configuration target channel
//   CFG_DIV_i    new reload value
//   CFG_READY_o  write can be accepted (combinational on CFG_CH_i)
//   OUT_o        divided clock (toggle) or strobe (pulse), registered
//   TC_o         one-cycle terminal-count strobe, registered
// ----------------------------------------------------------------------------
module multi_clk_divider #(
   parameter int BW       = 8,
   parameter int NCH      = 4,
   parameter int PRESCALE = 4,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [NCH-1:0] EN_i,
   input  logic [NCH-1:0] MODE_i,
   input  logic           CFG_VALID_i,
   input  logic [CHW-1:0] CFG_CH_i,
   input  logic [BW-1:0]  CFG_DIV_i,
   output logic           CFG_READY_o,
   output logic [NCH-1:0] OUT_o,
   output logic [NCH-1:0] TC_o
);

   generate
      if (NCH < 1 || PRESCALE < 1 || BW < 1) begin : g_param_check
         $error("multi_clk_divider: NCH, PRESCALE and BW must all be at least 1");
      end
   endgenerate

   logic tick;

`ifdef MCD_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   // Tick is asserted while the prescaler sits at its last value, so the
   // first tick lands on the PRESCALE-th edge after reset.
   assign tick = (pre_q == PW'(PRESCALE - 1));

   always_comb begin
      pre_d = pre_q + PW'(1);
      if (tick) begin
         pre_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   logic [NCH-1:0] sel;
   logic [NCH-1:0] pend_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [BW-1:0] cnt_q, cnt_d;
         logic [BW-1:0] div_q, div_d;
         logic [BW-1:0] shadow_q, shadow_d;
         logic          pend_q, pend_d;
         logic          out_q, out_d;
         logic          tc_q, tc_d;
         logic          accept;

         // An out-of-range CFG_CH_i selects no channel, so the write is dropped.
         assign sel[gi]      = (CFG_CH_i == CHW'(gi));
         assign pend_vec[gi] = pend_q;
         // Only possible while nothing is pending, so it never collides with
         // the pending value being applied in the same cycle.
         assign accept       = CFG_VALID_i & sel[gi] & ~pend_q;

         always_comb begin
            cnt_d    = cnt_q;
            div_d    = div_q;
            shadow_d = shadow_q;
            pend_d   = pend_q;
            tc_d     = 1'b0;
            // Pulse mode drops the strobe on any non-terminal edge; toggle holds.
            out_d    = MODE_i[gi] ? 1'b0 : out_q;

            if (EN_i[gi]) begin
               if (tick) begin
                  if (cnt_q == '0) begin
                     if (pend_q) begin
                        div_d  = shadow_q;
                        cnt_d  = shadow_q;
                        pend_d = 1'b0;
                     end else begin
                        cnt_d  = div_q;
                     end
                     tc_d  = 1'b1;
                     out_d = MODE_i[gi] ? 1'b1 : ~out_q;
                  end else begin
                     cnt_d = cnt_q - BW'(1);
                  end
               end
            end else if (pend_q) begin
               // A stopped channel has no terminal count to wait for.
               div_d  = shadow_q;
               cnt_d  = shadow_q;
               pend_d = 1'b0;
            end

            if (accept) begin
               shadow_d = CFG_DIV_i;
               pend_d   = 1'b1;
            end
         end

         always_ff @(posedge CLK) begin
            if (RST) begin
               cnt_q    <= '1;
               div_q    <= '1;
               shadow_q <= '0;
               pend_q   <= 1'b0;
               out_q    <= 1'b0;
               tc_q     <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               div_q    <= div_d;
               shadow_q <= shadow_d;
               pend_q   <= pend_d;
               out_q    <= out_d;
               tc_q     <= tc_d;
            end
         end

         assign OUT_o[gi] = out_q;
         assign TC_o[gi]  = tc_q;
      end
   endgenerate

   assign CFG_READY_o = ~|(sel & pend_vec);

endmodule

// File: tb/tb_multi_clk_divider.sv
`timescale 1ns/1ps
module tb_multi_clk_divider;
   localparam int BW       = 8;
   localparam int NCH      = 4;
   localparam int PRESCALE = 4;
   localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef MCD_PRESCALE_EN
   localparam int PEFF = PRESCALE;
`else
   localparam int PEFF = 1;
`endif
   localparam int ALL1 = (1 << BW) - 1;

   logic           CLK = 1'b0;
   logic           RST;
   logic [NCH-1:0] en, mode;
   logic           vld;
   logic [CHW-1:0] ch;
   logic [BW-1:0]  dv;
   logic           rdy;
   logic [NCH-1:0] out, tc;

   always #5 CLK = ~CLK;

   multi_clk_divider #(.BW(BW), .NCH(NCH), .PRESCALE(PRESCALE)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .EN_i        (en),
      .MODE_i      (mode),
      .CFG_VALID_i (vld),
      .CFG_CH_i    (ch),
      .CFG_DIV_i   (dv),
      .CFG_READY_o (rdy),
      .OUT_o       (out),
      .TC_o        (tc)
   );

   int compared   = 0;
   int mismatched = 0;
   int n = 0;

   typedef struct {
      logic [NCH-1:0] out;
      logic [NCH-1:0] tc;
      logic           rdy;
      int             cyc;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: per-channel "ticks left until terminal count" plus the
   // divisor bookkeeping, advanced one clock at a time with plain integers.
   int m_left[NCH];
   int m_div[NCH];
   int m_shadow[NCH];
   bit m_pend[NCH];
   bit m_out[NCH];
   bit m_tc[NCH];
   int m_edges;

   function automatic bit m_ready(int c);
      if (c >= NCH) return 1'b1;
      return !m_pend[c];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_left[i] = ALL1; m_div[i] = ALL1; m_shadow[i] = 0;
         m_pend[i] = 0; m_out[i] = 0; m_tc[i] = 0;
      end
      m_edges = 0;
   endtask

   task automatic model_edge();
      bit tk;
      bit acc;
      if (RST) begin
         model_reset();
         return;
      end
      tk = ((m_edges + 1) % PEFF) == 0;
      m_edges++;
      for (int i = 0; i < NCH; i++) begin
         acc = vld && (int'(ch) == i) && !m_pend[i];
         m_tc[i] = 0;
         if (mode[i]) m_out[i] = 0;
         if (!en[i]) begin
            if (m_pend[i]) begin
               m_div[i] = m_shadow[i]; m_left[i] = m_shadow[i]; m_pend[i] = 0;
            end
         end else if (tk) begin
            if (m_left[i] == 0) begin
               if (m_pend[i]) begin
                  m_div[i] = m_shadow[i]; m_pend[i] = 0;
               end
               m_left[i] = m_div[i];
               m_tc[i]   = 1;
               m_out[i]  = mode[i] ? 1'b1 : !m_out[i];
            end else begin
               m_left[i] = m_left[i] - 1;
            end
         end
         if (acc) begin
            m_shadow[i] = int'(dv); m_pend[i] = 1;
         end
      end
   endtask

   task automatic check(string name, int got, int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   // Push what the DUT must show during this cycle, then advance one edge.
   task automatic step();
      exp_t e;
      for (int i = 0; i < NCH; i++) begin
         e.out[i] = m_out[i];
         e.tc[i]  = m_tc[i];
      end
      e.rdy = m_ready(int'(ch));
      e.cyc = n;
      exp_q.push_back(e);
      model_edge();
      @(posedge CLK);
      #1;
      n++;
   endtask

   // Monitor: outputs are presented every cycle; compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (out !== e.out || tc !== e.tc || rdy !== e.rdy) begin
               mismatched++;
               $display("FAIL sb cycle %0d: got out=%b tc=%b rdy=%b, required out=%b tc=%b rdy=%b",
                        e.cyc, out, tc, rdy, e.out, e.tc, e.rdy);
            end
         end
      end
   end

   initial begin
      int first_tc, second_tc, first_out, cnt1, cnt3;
      RST = 1'b1; en = '0; mode = '0; vld = 1'b0; ch = '0; dv = '0;
      @(posedge CLK);
      #1;
      model_reset();
      RST = 1'b0;
      check("reset_out", int'(out), 0);
      check("reset_tc", int'(tc), 0);
      check("reset_ready", int'(rdy), 1);

      // Free-running channel 0 with the reset divisor.
      en = 4'b0001;
      first_tc = -1; second_tc = -1; first_out = -1;
      repeat (600 * PEFF) begin
         step();
         if (tc[0]) begin
            if (first_tc < 0) first_tc = n;
            else if (second_tc < 0) second_tc = n;
         end
         if (out[0] && first_out < 0) first_out = n;
      end
      check("first_tc0", first_tc, 256 * PEFF);
      check("second_tc0", second_tc, 512 * PEFF);
      check("first_out0_rise", first_out, 256 * PEFF);

      // Channel 1: program DIV=3 while stopped, then pulse mode.
      vld = 1'b1; ch = 2'd1; dv = 8'd3;
      step();
      vld = 1'b0;
      step();
      en[1] = 1'b1; mode[1] = 1'b1;
      cnt1 = 0;
      repeat (40 * PEFF) begin
         step();
         if (tc[1] && out[1]) cnt1++;
      end
      check("ch1_pulses_div3", cnt1, 10);

      // Channel 3: DIV=0, pulse mode holds strobe high, then toggle mode.
      vld = 1'b1; ch = 2'd3; dv = 8'd0;
      step();
      vld = 1'b0;
      step();
      en[3] = 1'b1; mode[3] = 1'b1;
      cnt3 = 0;
      repeat (20 * PEFF) begin
         step();
         if (tc[3] && out[3]) cnt3++;
      end
      check("ch3_div0_pulse", cnt3, 20);
      mode[3] = 1'b0;
      repeat (20 * PEFF) step();

      // Channel 2: DIV=9 running, rewrite to 1 mid-count, second write stalls.
      vld = 1'b1; ch = 2'd2; dv = 8'd9;
      step();
      vld = 1'b0;
      step();
      en[2] = 1'b1;
      repeat (3 * PEFF) step();
      vld = 1'b1; dv = 8'd1;
      step();
      check("ready_low_after_write", int'(rdy), 0);
      dv = 8'd5;
      for (int g = 0; g < 200 * PEFF && !m_ready(2); g++) step();
      check("ready_released", int'(rdy), 1);
      step();
      vld = 1'b0;
      repeat (12 * PEFF) step();

      // Reset mid-count with a write pending; the write in the reset cycle is dropped.
      vld = 1'b1; dv = 8'd7;
      step();
      RST = 1'b1;
      step();
      RST = 1'b0; vld = 1'b0;
      check("midrst_out", int'(out), 0);
      check("midrst_tc", int'(tc), 0);
      check("midrst_ready", int'(rdy), 1);
      repeat (20) step();

      // Randomised traffic.
      for (int k = 0; k < 4000; k++) begin
         RST = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) en = NCH'($urandom);
         if ($urandom_range(0, 31) == 0) mode = NCH'($urandom);
         vld = ($urandom_range(0, 3) == 0);
         ch  = CHW'($urandom);
         dv  = ($urandom_range(0, 3) == 0) ? BW'($urandom) : BW'($urandom_range(0, 7));
         step();
      end
      RST = 1'b0; vld = 1'b0;
      @(negedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
